// File: rtl/numbers_arith_result_serializer.sv
// Buffers packed 25-bit arithmetic result words in a small FIFO and emits
// each word as five 5-bit fields (sum, diff, prod, quot, rem), one per cycle.
//
// Handshakes (both sides): a transfer happens on a rising edge where
// valid && ready. The block never combinationally depends on the partner's
// valid/ready: in_ready comes from registered occupancy only, out_valid and
// the field outputs come from registered state only, and they hold steady
// while out_ready is low.
module numbers_arith_result_serializer #(
  parameter int DEPTH   = 4,
  parameter int FIELD_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5*FIELD_W-1:0]     in_flat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FIELD_W-1:0]       out_field,
  output logic [2:0]               out_idx,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          WORD_W   = 5 * FIELD_W;
  localparam logic [AW:0] DEPTH_C  = DEPTH[AW:0];
  localparam logic [2:0]  LAST_IDX = 3'd4;

  logic [WORD_W-1:0]  mem_q [DEPTH];
  logic [WORD_W-1:0]  mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [2:0]         idx_q, idx_d;

  logic               push;
  logic               xfer;
  logic               pop;
  logic [WORD_W-1:0]  head;
  logic [FIELD_W-1:0] field_sel;

  // Handshake decode from registered state; the final-field transfer pops the head word.
  always_comb begin
    in_ready  = (count_q < DEPTH_C);
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    xfer      = out_valid && out_ready;
    pop       = xfer && (idx_q == LAST_IDX);
    head      = mem_q[rd_ptr_q];
    occupancy = count_q;
    out_idx   = idx_q;
    out_last  = (idx_q == LAST_IDX);
  end

  // Select the head-word field named by the field counter; sum sits in the top bits.
  always_comb begin
    field_sel = '0;
    case (idx_q)
      3'd0:    field_sel = head[4*FIELD_W +: FIELD_W];
      3'd1:    field_sel = head[3*FIELD_W +: FIELD_W];
      3'd2:    field_sel = head[2*FIELD_W +: FIELD_W];
      3'd3:    field_sel = head[1*FIELD_W +: FIELD_W];
      3'd4:    field_sel = head[0 +: FIELD_W];
      default: field_sel = '0;
    endcase
    // Stale storage is never shown: the field bus reads zero while empty.
    out_field = out_valid ? field_sel : '0;
  end

  // Next-state for storage, pointers, occupancy and field counter.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    idx_d    = idx_q;

    if (push) begin
      mem_d[wr_ptr_q] = in_flat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    if (xfer) begin
      if (idx_q == LAST_IDX) begin
        idx_d    = 3'd0;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end

    // Push and pop together leave occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State register; reset wins over any concurrent push or pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= 3'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: tb/tb_numbers_arith_result_serializer.sv
// Bench for numbers_arith_result_serializer: a negedge monitor keeps a queue
// of expected {idx, field} pairs, filled when a word is accepted and drained
// when a field transfers; scenario tasks add their own inline checks.
module tb_numbers_arith_result_serializer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_flat;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_field;
  logic [2:0]  out_idx;
  logic        out_last;
  logic [2:0]  occupancy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  numbers_arith_result_serializer #(.DEPTH(4), .FIELD_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_flat   (in_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_field (out_field),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .occupancy (occupancy)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: compare transfers that will happen at the next edge,
  // then record fields of a word that will be accepted at that edge.
  always @(negedge clk) begin
    logic [7:0] exp_v;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (!out_valid) begin
        checks++;
        if (out_field !== 5'd0) begin
          failures++;
          $display("FAIL idle_field: got %0d required 0", out_field);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got idx=%0d field=%0d required no output", out_idx, out_field);
        end else begin
          exp_v = exp_q.pop_front();
          checks++;
          if ({out_idx, out_field} !== exp_v) begin
            failures++;
            $display("FAIL sb_field: got idx=%0d field=%0d required idx=%0d field=%0d",
                     out_idx, out_field, exp_v[7:5], exp_v[4:0]);
          end
          checks++;
          if (out_last !== (exp_v[7:5] == 3'd4)) begin
            failures++;
            $display("FAIL sb_last: got %0b required %0b at idx %0d",
                     out_last, (exp_v[7:5] == 3'd4), exp_v[7:5]);
          end
        end
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < 5; k++) begin
          exp_q.push_back({3'(k), in_flat[(4-k)*5 +: 5]});
        end
      end
    end
  end

  // Driver: present a word until accepted; returns just after the accepting edge.
  task automatic push_word(input logic [24:0] w);
    bit done;
    done     = 1'b0;
    in_flat  = w;
    in_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: got in_ready=0 required acceptance of %h", w);
    end
  endtask

  // Driver: let the output drain, then confirm everything expected came out.
  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (occupancy == 3'd0) break;
    end
    checks++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain_occ: got occ=%0d valid=%0b required occ=0 valid=0", name, occupancy, out_valid);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain_sb: got %0d fields missing required 0", name, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_flat   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
    checks++;
    if (out_idx !== 3'd0) begin failures++; $display("FAIL rst_out_idx: got %0d required 0", out_idx); end
    checks++;
    if (out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last: got %0b required 0", out_last); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %0b required 1", in_ready); end
    checks++;
    if (occupancy !== 3'd0) begin failures++; $display("FAIL rst_occupancy: got %0d required 0", occupancy); end
    checks++;
    if (out_field !== 5'd0) begin failures++; $display("FAIL rst_out_field: got %0d required 0", out_field); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int cyc;
    out_ready = 1'b1;
    push_word({5'd3, 5'd1, 5'd12, 5'd2, 5'd0});
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_field !== 5'd3) begin
      failures++;
      $display("FAIL single_latency: got valid=%0b idx=%0d field=%0d required valid=1 idx=0 field=3",
               out_valid, out_idx, out_field);
    end
    cyc = 0;
    while (occupancy != 3'd0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 5) begin
      failures++;
      $display("FAIL single_cycles: got %0d cycles required 5", cyc);
    end
    @(posedge clk);
    #1;
    drain("single");
  endtask

  task automatic test_fill_and_concurrent();
    logic [24:0] w5;
    bit          found;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_flat  = {5'(i + 8), 20'($urandom)};
      in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (occupancy !== 3'(i) || in_ready !== (i < 4)) begin
        failures++;
        $display("FAIL fill_step%0d: got occ=%0d ready=%0b required occ=%0d ready=%0b",
                 i, occupancy, in_ready, i, (i < 4));
      end
      @(posedge clk);
      #1;
    end
    w5 = in_flat;
    @(negedge clk);
    checks++;
    if (occupancy !== 3'd4 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: got occ=%0d ready=%0b required occ=4 ready=0", occupancy, in_ready);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (out_idx == 3'd4) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || occupancy !== 3'd4 || in_ready !== 1'b0 || in_flat !== w5) begin
      failures++;
      $display("FAIL conc_pop_cycle: got found=%0b occ=%0d ready=%0b required found=1 occ=4 ready=0",
               found, occupancy, in_ready);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (occupancy !== 3'd3 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL conc_after_pop: got occ=%0d ready=%0b required occ=3 ready=1", occupancy, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (occupancy !== 3'd4) begin
      failures++;
      $display("FAIL conc_accept: got occ=%0d required 4", occupancy);
    end
    @(posedge clk);
    #1;
    drain("fill");
  endtask

  task automatic test_backpressure();
    bit         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit         prev_stall;
    logic [8:0] saved;
    out_ready  = 1'b0;
    prev_stall = 1'b0;
    saved      = '0;
    push_word({5'd17, 5'd5, 5'd30, 5'd9, 5'd21});
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = pat[cyc % 4];
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if ({out_idx, out_field, out_last} !== saved) begin
          failures++;
          $display("FAIL bp_hold: got idx=%0d field=%0d last=%0b required idx=%0d field=%0d last=%0b",
                   out_idx, out_field, out_last, saved[8:6], saved[5:1], saved[0]);
        end
      end
      if (!out_valid) break;
      saved      = {out_idx, out_field, out_last};
      prev_stall = !out_ready;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    drain("bp");
  endtask

  task automatic test_reset_mid_word();
    logic [24:0] w3;
    bit          found;
    out_ready = 1'b0;
    push_word({5'd1, 5'd2, 5'd3, 5'd4, 5'd5});
    push_word({5'd6, 5'd7, 5'd8, 5'd9, 5'd10});
    out_ready = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (out_idx == 3'd2) begin
        found = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    // Reset lands with a final-field-free transfer and a push both pending.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_flat  = {5'd31, 5'd31, 5'd31, 5'd31, 5'd31};
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (!found || occupancy !== 3'd0 || out_valid !== 1'b0 || out_idx !== 3'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_state: got found=%0b occ=%0d valid=%0b idx=%0d ready=%0b required found=1 occ=0 valid=0 idx=0 ready=1",
               found, occupancy, out_valid, out_idx, in_ready);
    end
    @(posedge clk);
    #1;
    w3 = {5'd11, 5'd22, 5'd0, 5'd14, 5'd27};
    push_word(w3);
    @(negedge clk);
    checks++;
    if (out_idx !== 3'd0 || out_field !== 5'd11) begin
      failures++;
      $display("FAIL rstmid_restart: got idx=%0d field=%0d required idx=0 field=11", out_idx, out_field);
    end
    @(posedge clk);
    #1;
    drain("rstmid");
  endtask

  task automatic test_back_to_back_wrap();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_word({5'(i), 20'($urandom_range(0, 20'hFFFFF))});
    end
    drain("wrap");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_and_concurrent();
    test_backpressure();
    test_reset_mid_word();
    test_back_to_back_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/numbers_arith_result_serializer.md
NUMBERS_ARITH_RESULT_SERIALIZER -- requirements
Module: numbers_arith_result_serializer

Interface
REQ-001 Parameter: DEPTH, default 4, number of 25-bit result words buffered; SHALL be a power of two and at least 2.
REQ-002 Parameter: FIELD_W, default 5, width of each result field; fixed at 5 for this release.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in_valid  input  1  upstream result word present on in_flat.
REQ-006 Port: in_ready  output  1  block can accept a word this cycle.
REQ-007 Port: in_flat  input  25  packed arithmetic results: [24:20] sum_ab, [19:15] diff_ab, [14:10] prod_ab, [9:5] quot_ab, [4:0] rem_ab.
REQ-008 Port: out_valid  output  1  out_field holds a valid field.
REQ-009 Port: out_ready  input  1  downstream accepts the field this cycle.
REQ-010 Port: out_field  output  5  current result field.
REQ-011 Port: out_idx  output  3  field index: 0=sum, 1=diff, 2=prod, 3=quot, 4=rem.
REQ-012 Port: out_last  output  1  high with field index 4 (last field of the word).
REQ-013 Port: occupancy  output  $clog2(DEPTH)+1  words currently buffered, including the word being serialized.

Function
REQ-014 The block SHALL store accepted words in a DEPTH-entry FIFO with wrapping read/write pointers.
REQ-015 in_ready SHALL equal (occupancy < DEPTH), computed from registered state only; there is no same-cycle pass-through of a freed slot.
REQ-016 A word SHALL be accepted on a rising edge where in_valid && in_ready; in_flat is ignored otherwise.
REQ-017 out_valid SHALL equal (occupancy != 0).
REQ-018 out_field SHALL be the field of the head word selected by the field counter: idx 0 -> [24:20], 1 -> [19:15], 2 -> [14:10], 3 -> [9:5], 4 -> [4:0].
REQ-019 A field transfer SHALL occur on a rising edge where out_valid && out_ready; the field counter then increments by 1.
REQ-020 On the transfer where out_idx == 4, the field counter SHALL wrap to 0 and the head word SHALL be popped in the same edge.
REQ-021 While out_valid && !out_ready, out_field, out_idx and out_last SHALL hold stable.
REQ-022 Latency: a word accepted into an empty FIFO at edge N SHALL present field 0 with out_valid=1 after edge N.
REQ-023 A word SHALL occupy exactly 5 output transfers; at most one field per cycle.
REQ-024 Simultaneous push and final-field pop in one edge SHALL leave occupancy unchanged, with both operations taking effect.
REQ-025 When full, a final-field pop SHALL raise in_ready after that edge; no word may be written while in_ready=0.
REQ-026 The field counter SHALL never exceed 4; out_idx outside 0..4 is an implementation error.
REQ-027 Field values SHALL pass through unmodified; no arithmetic is performed on the data.

Reset
REQ-028 While rst=1 at a rising edge, the block SHALL empty the FIFO, clear pointers, clear the field counter and set occupancy to 0.
REQ-029 After reset: out_valid=0, out_idx=0, out_last=0, in_ready=1; out_field SHALL be 0 while out_valid=0.
REQ-030 Reset asserted mid-word SHALL discard the partial word and all buffered words; no field is emitted after the reset edge until a new word is accepted.
REQ-031 Reset SHALL take priority over simultaneous push and pop in the same cycle.

Verification
REQ-032 Single word: push in_flat={5'd3,5'd1,5'd12,5'd2,5'd0} with out_ready=1 -> out_field 3,1,12,2,0 on idx 0..4 in five consecutive cycles; out_last=1 only on 0; occupancy returns to 0.
REQ-033 Fill: DEPTH=4, out_ready=0, push 5 words back-to-back -> first 4 accepted, in_ready=0 from the cycle after the 4th, occupancy=4, 5th word held by upstream.
REQ-034 Backpressure: toggle out_ready 1,0,0,1 during a word -> each field held while stalled; no field skipped or repeated.
REQ-035 Full with concurrent push/pop: occupancy=4, final-field transfer plus in_valid=1 -> occupancy stays 4 only after in_ready rises; the new word is accepted one cycle after the pop, not in the pop cycle.
REQ-036 Reset mid-word: assert rst after idx 2 of word 0 with 2 words buffered -> occupancy=0, out_valid=0 next cycle; next pushed word starts at idx 0.
REQ-037 Pointer wrap: stream 10 distinct words at full throughput through DEPTH=4 -> all 50 fields emitted in push order with correct values.
